uart_secded_tx: RTL and testbench

UART_SECDED_TX -- requirements
Module: uart_secded_tx

---
 rtl/uart_secded_tx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_secded_tx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_secded_tx.sv
// rtl/uart_secded_tx.sv - UART transmitter with TX FIFO and optional SEC-DED nibble framing
module uart_secded_tx #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 16,
  parameter int SAMPLE    = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_tick,
  input  logic                 trans,
  input  logic [DATA_SIZE-1:0] bus_data_in,
  input  logic                 ecc_mode,
  input  logic                 clr_ovf,
  output logic                 tx,
  output logic                 wait_request_write,
  output logic [2:0]           TX_status_register,
  output logic                 busy
);

  localparam int AW         = (SIZE_FIFO > 1) ? $clog2(SIZE_FIFO) : 1;
  localparam int CW         = $clog2(SIZE_FIFO + 1);
  localparam int SH_W       = (DATA_SIZE > 8) ? DATA_SIZE : 8;
  localparam int BW         = $clog2(SH_W + 1);
  localparam int STOP_TICKS = STOP_BITS * SAMPLE;
  localparam int TW         = $clog2(STOP_TICKS + 1);
  localparam int NFR        = DATA_SIZE / 4;
  localparam int FW         = $clog2(NFR + 1);

  localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(SIZE_FIFO);
  localparam logic [TW-1:0] BIT_LAST      = TW'(SAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST     = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] RAW_LAST      = BW'(DATA_SIZE - 1);
  localparam logic [BW-1:0] ECC_LAST      = BW'(7);
  localparam logic [FW-1:0] ECC_FRAMES    = FW'(NFR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Codeword layout {p0,d3,d2,d1,p3,d0,p2,p1}; p0 makes overall parity even.
  function automatic logic [7:0] secded_enc(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    return {^c, c};
  endfunction

  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 fifo_full, fifo_empty, push, pop;

  state_t               state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [BW-1:0]        bit_cnt, bit_n, frame_last;
  logic [SH_W-1:0]      shreg, sh_n;
  logic [DATA_SIZE-1:0] word_rem, word_n, pop_word;
  logic [FW-1:0]        frames_left, frames_n;
  logic                 ecc_lat, ecc_n;
  logic                 tx_reg, tx_n;

  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign fifo_empty = (count == '0);
  assign push       = trans & ~fifo_full;
  assign pop_word   = mem[rd_ptr];
  assign frame_last = ecc_lat ? ECC_LAST : RAW_LAST;

  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    word_n   = word_rem;
    frames_n = frames_left;
    ecc_n    = ecc_lat;
    pop      = 1'b0;
    tx_n     = 1'b1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = DATA;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_n = '0;
            if (bit_cnt == frame_last) begin
              state_n = STOP;
            end else begin
              bit_n = bit_cnt + BW'(1);
              sh_n  = shreg >> 1;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_n = '0;
            // Remaining nibbles go out first; otherwise chain straight into the next FIFO word.
            if (frames_left != '0) begin
              frames_n = frames_left - FW'(1);
              sh_n     = SH_W'(secded_enc(word_rem[3:0]));
              word_n   = word_rem >> 4;
              state_n  = START;
            end else if (!fifo_empty) begin
              pop     = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) begin
      tick_n = '0;
      ecc_n  = ecc_mode;
      if (ecc_mode) begin
        sh_n     = SH_W'(secded_enc(pop_word[3:0]));
        word_n   = pop_word >> 4;
        frames_n = ECC_FRAMES;
      end else begin
        sh_n     = SH_W'(pop_word);
        word_n   = pop_word;
        frames_n = '0;
      end
    end

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      word_rem    <= '0;
      frames_left <= '0;
      ecc_lat     <= 1'b0;
      tx_reg      <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shreg       <= sh_n;
      word_rem    <= word_n;
      frames_left <= frames_n;
      ecc_lat     <= ecc_n;
      tx_reg      <= tx_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A fresh overflow wins over a simultaneous clear.
      if (trans && fifo_full) overflow <= 1'b1;
      else if (clr_ovf)       overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_data_in;
  end

  assign tx                 = tx_reg;
  assign busy               = (state != IDLE);
  assign wait_request_write = fifo_full;
  assign TX_status_register = {overflow, fifo_full, fifo_empty};

endmodule

// File: tb/tb_uart_secded_tx.sv
// tb/tb_uart_secded_tx.sv - directed self-checking bench for uart_secded_tx
module tb_uart_secded_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       trans = 1'b0;
  logic [7:0] bus_data_in = 8'h00;
  logic       ecc_mode = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       tx;
  logic       wait_request_write;
  logic [2:0] TX_status_register;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_t0 = 0;
  int last_end = 0;
  int cp = 0;

  logic [7:0] vec5 [5]   = '{8'hFF, 8'h55, 8'hAB, 8'hCD, 8'hEA};
  logic [7:0] vec16 [16] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                             8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};

  uart_secded_tx dut (
    .clk                (clk),
    .reset              (reset),
    .s_tick             (s_tick),
    .trans              (trans),
    .bus_data_in        (bus_data_in),
    .ecc_mode           (ecc_mode),
    .clr_ovf            (clr_ovf),
    .tx                 (tx),
    .wait_request_write (wait_request_write),
    .TX_status_register (TX_status_register),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus_data_in = d;
    trans = 1'b1;
    step();
    trans = 1'b0;
    cp = cyc;
  endtask

  // Receives one 8-bit frame at SAMPLE=16 with s_tick held high, sampling mid-bit.
  task automatic rx_frame(input string tag, input logic [7:0] exp, input bit chk_gap);
    int n;
    int gap;
    logic [7:0] v;
    n = 0;
    v = '0;
    while (tx !== 1'b0 && n < 4000) begin
      step();
      n++;
    end
    check({tag, "_start"}, 32'(tx), 32'd0);
    last_t0 = cyc;
    if (chk_gap) begin
      gap = last_t0 - last_end;
      check({tag, "_gap"}, 32'((gap == 0) || (gap == 1)), 32'd1);
    end
    repeat (8) step();
    for (int i = 0; i < 8; i++) begin
      repeat (16) step();
      v[i] = tx;
    end
    repeat (16) step();
    check({tag, "_stop"}, 32'(tx), 32'd1);
    last_end = last_t0 + 160;
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      step();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", 32'(TX_status_register), 32'h1);
    check("rst_wrw", 32'(wait_request_write), 32'd0);
    step();
    reset = 1'b0;
    step();

    // raw 0x55
    s_tick = 1'b1;
    ecc_mode = 1'b0;
    push(8'h55);
    rx_frame("raw55", 8'h55, 1'b0);
    check("raw55_latency", 32'(last_t0 - cp), 32'd1);
    check("raw55_busy_stop", 32'(busy), 32'd1);
    repeat (8) step();
    check("raw55_busy_after", 32'(busy), 32'd0);
    check("raw55_tx_after", 32'(tx), 32'd1);

    // SEC-DED words
    ecc_mode = 1'b1;
    push(8'hA5);
    rx_frame("eccA5_0", 8'h2D, 1'b0);
    rx_frame("eccA5_1", 8'hD2, 1'b1);
    wait_idle("eccA5_idle");
    push(8'hFF);
    rx_frame("eccFF_0", 8'hFF, 1'b0);
    rx_frame("eccFF_1", 8'hFF, 1'b1);
    wait_idle("eccFF_idle");
    push(8'h00);
    rx_frame("ecc00_0", 8'h00, 1'b0);
    rx_frame("ecc00_1", 8'h00, 1'b1);
    wait_idle("ecc00_idle");

    // ecc_mode and data change after the pop must not affect the word
    push(8'h5A);
    step();
    ecc_mode = 1'b0;
    bus_data_in = 8'hFF;
    rx_frame("ecc5A_0", 8'hD2, 1'b0);
    rx_frame("ecc5A_1", 8'h2D, 1'b1);
    wait_idle("ecc5A_idle");
    push(8'h5A);
    rx_frame("raw5A", 8'h5A, 1'b0);
    wait_idle("raw5A_idle");

    // five queued raw words, released together
    s_tick = 1'b0;
    trans = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_data_in = vec5[i];
      step();
    end
    trans = 1'b0;
    check("q5_status", 32'(TX_status_register), 32'h0);
    s_tick = 1'b1;
    for (int i = 0; i < 5; i++) rx_frame($sformatf("q5_%0d", i), vec5[i], i > 0);
    wait_idle("q5_idle");

    // fill and overflow: one word held by the frozen FSM, then 16 more into the FIFO
    s_tick = 1'b0;
    push(8'h11);
    step();
    trans = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_data_in = vec16[i];
      step();
    end
    trans = 1'b0;
    check("full_wrw", 32'(wait_request_write), 32'd1);
    check("full_status", 32'(TX_status_register), 32'h2);
    push(8'hEE);
    check("ovf_status", 32'(TX_status_register), 32'h6);
    clr_ovf = 1'b1;
    push(8'hDD);
    check("ovf_clr_same_edge", 32'(TX_status_register), 32'h6);
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(TX_status_register), 32'h2);
    s_tick = 1'b1;
    rx_frame("hold", 8'h11, 1'b0);
    for (int i = 0; i < 16; i++) rx_frame($sformatf("fifo_%0d", i), vec16[i], 1'b1);
    wait_idle("fifo_idle");
    repeat (40) step();
    check("dropped_tx", 32'(tx), 32'd1);
    check("dropped_busy", 32'(busy), 32'd0);
    check("drained_status", 32'(TX_status_register), 32'h1);

    // reset in the middle of data bit 3
    push(8'h96);
    push(8'h77);
    begin
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 200) begin
        step();
        n++;
      end
    end
    repeat (16 + 48 + 8) step();
    check("mid_bit3_tx", 32'(tx), 32'd0);
    check("mid_bit3_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_status", 32'(TX_status_register), 32'h1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wrw", 32'(wait_request_write), 32'd0);
    step();
    step();
    reset = 1'b0;
    repeat (30) step();
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_tx", 32'(tx), 32'd1);
    push(8'h3C);
    rx_frame("raw3C", 8'h3C, 1'b0);
    wait_idle("raw3C_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
